// File: rtl/memory_loader.sv
// Byte-stream program loader: parses sync/addr/count/data/checksum frames and
// drives the write port of the dual-bank memory_block with packed 16-bit words.
module memory_loader #(
  parameter int WIDTH   = 15,
  parameter int TIMEOUT = 1023
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             write_enable,
  output logic [WIDTH-1:0] write_address,
  output logic [15:0]      write_data,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       error_code
);

  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L, CSUM
  } state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic [7:0]       hold;      // high byte of the field being assembled
  logic [15:0]      field;
  logic [WIDTH-1:0] addr;
  logic [15:0]      count;
  logic [7:0]       sum, sum_nxt;
  logic [15:0]      tcnt;
  logic             timeout_hit;

  assign accept  = rx_valid & rx_ready;
  assign field   = {hold, rx_data};
  assign sum_nxt = sum + rx_data;
  assign busy    = (state != IDLE);

  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout_hit = busy && !accept && (tcnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout_hit) begin
      state_nxt = IDLE;
    end else if (accept) begin
      case (state)
        IDLE:    if (rx_data == SYNC) state_nxt = ADDR_H;
        ADDR_H:  state_nxt = ADDR_L;
        ADDR_L:  state_nxt = CNT_H;
        CNT_H:   state_nxt = CNT_L;
        CNT_L:   state_nxt = (field == 16'd0) ? CSUM : DATA_H;
        DATA_H:  state_nxt = DATA_L;
        DATA_L:  state_nxt = (count == 16'd1) ? CSUM : DATA_H;
        CSUM:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_ready      <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
      error_code    <= 2'b00;
      hold          <= '0;
      addr          <= '0;
      count         <= '0;
      sum           <= '0;
      tcnt          <= '0;
    end else begin
      rx_ready     <= 1'b1;
      write_enable <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      if (accept) begin
        tcnt <= '0;
        if (state == IDLE) begin
          if (rx_data == SYNC) begin
            sum        <= '0;
            error_code <= 2'b00;
          end
        end else begin
          sum <= sum_nxt;
        end
        case (state)
          ADDR_H, CNT_H, DATA_H: hold <= rx_data;
          ADDR_L: addr  <= field[WIDTH-1:0];
          CNT_L:  count <= field;
          DATA_L: begin
            write_enable  <= 1'b1;
            write_address <= addr;
            write_data    <= field;
            addr          <= addr + WIDTH'(1);
            count         <= count - 16'd1;
          end
          CSUM: begin
            if (sum_nxt == 8'h00) begin
              done <= 1'b1;
            end else begin
              error      <= 1'b1;
              error_code <= 2'b01;
            end
          end
          default: ;
        endcase
      end else if (timeout_hit) begin
        error      <= 1'b1;
        error_code <= 2'b10;
      end else if (busy) begin
        tcnt <= tcnt + 16'd1;
      end
    end
  end

endmodule
